scaler_phase_ctrl: RTL and testbench

//  Horizontal phase sequencer for the linear-interpolation scaler; one line per start pulse.

---
 rtl/scaler2_pkg.sv | 24 ++
 rtl/scaler_phase_acc.sv | 43 ++++
 rtl/scaler_phase_ctrl.sv | 145 ++++++++++++++
 tb/tb_scaler_phase_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/scaler2_pkg.sv
// Shared types and constants for the horizontal scaler phase sequencer.
// No logic of its own; used by the phase accumulator and the sequencer top.
// No flow control here.
package scaler2_pkg;

  localparam int STEP_DEF    = 4096;
  localparam int SCALE_W_DEF = 16;
  localparam int LINE_W_DEF  = 12;
  localparam int STEP_LOG2   = $clog2(STEP_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Accumulator width: integer pixel index plus fraction, with one guard bit
  // so the position one step past the last pixel still fits.
  function automatic int acc_width(input int line_w, input int step_log2);
    return line_w + step_log2 + 1;
  endfunction

endpackage

// File: rtl/scaler_phase_acc.sv
// Output-pixel position accumulator, split into integer index and ROM index.
// Latency: idx/dx reflect the register, updated one cycle after clr/adv.
// No flow control; the sequencer decides when to clear or advance.
module scaler_phase_acc
  import scaler2_pkg::*;
#(
  parameter int STEP    = STEP_DEF,
  parameter int SCALE_W = SCALE_W_DEF,
  parameter int LINE_W  = LINE_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      adv,
  input  logic [SCALE_W-1:0]        step,
  output logic [LINE_W:0]           idx,
  output logic [$clog2(STEP/2)-1:0] dx
);

  localparam int PH_BITS = $clog2(STEP);
  localparam int ACC_W   = acc_width(LINE_W, PH_BITS);
  localparam int DX_W    = $clog2(STEP / 2);

  logic [ACC_W-1:0]   acc_q;
  logic [PH_BITS-1:0] frac;

  // Position register: cleared at line start, advanced once per output pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (adv) begin
      acc_q <= acc_q + ACC_W'(step);
    end
  end

  assign idx  = acc_q[ACC_W-1:PH_BITS];
  assign frac = acc_q[PH_BITS-1:0];
  // The coefficient ROM holds half as many entries as there are phases.
  assign dx   = DX_W'(frac >> 1);

endmodule

// File: rtl/scaler_phase_ctrl.sv
// Horizontal phase sequencer: paces input-pixel intake and emits one descriptor per output pixel.
// Latency: first in_ready 1 cycle after start; descriptor valid the cycle after its last needed input.
// Backpressure: descriptor held stable while out_ready is low; in_ready never overlaps out_valid.
module scaler_phase_ctrl
  import scaler2_pkg::*;
#(
  parameter int STEP    = STEP_DEF,
  parameter int SCALE_W = SCALE_W_DEF,
  parameter int LINE_W  = LINE_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SCALE_W-1:0]        cfg_step,
  input  logic [LINE_W-1:0]         cfg_in_w,
  input  logic [LINE_W-1:0]         cfg_out_w,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(STEP/2)-1:0] out_dx,
  output logic [LINE_W-1:0]         out_idx,
  output logic                      out_edge,
  output logic                      out_last
);

  localparam int DX_W  = $clog2(STEP / 2);
  localparam int IDX_W = LINE_W + 1;

  state_t             state_q, state_d;
  logic [SCALE_W-1:0] step_q;
  logic [LINE_W-1:0]  in_w_q, out_w_q, in_cnt_q, out_cnt_q;
  logic [IDX_W-1:0]   acc_idx, idx_p1, in_w_m1, need;
  logic [DX_W-1:0]    acc_dx;
  logic               bad_cfg, feed, last_out, acc_clr;
  logic               in_xfer, out_xfer, done_q, err_q;

  scaler_phase_acc #(
    .STEP    (STEP),
    .SCALE_W (SCALE_W),
    .LINE_W  (LINE_W)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (acc_clr),
    .adv  (out_xfer),
    .step (step_q),
    .idx  (acc_idx),
    .dx   (acc_dx)
  );

  assign bad_cfg  = (cfg_in_w < LINE_W'(2)) || (cfg_out_w == '0) || (cfg_step == '0);
  // Pixels 0..need must be in hand before the descriptor for the current
  // position is issued; near the right edge that caps at the last pixel.
  assign idx_p1   = acc_idx + IDX_W'(1);
  assign in_w_m1  = {1'b0, in_w_q} - IDX_W'(1);
  assign need     = (idx_p1 < in_w_m1) ? idx_p1 : in_w_m1;
  assign feed     = ({1'b0, in_cnt_q} <= need);
  assign last_out = (out_cnt_q == out_w_q - LINE_W'(1));
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Next-state and handshake decode; a line only ever moves forward.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    acc_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_clr = 1'b1;
          state_d = bad_cfg ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (feed) begin
          in_ready = 1'b1;
        end else begin
          out_valid = 1'b1;
          if (out_ready && last_out) begin
            // Skip the tail-drain state when the line is already fully read.
            state_d = (in_cnt_q == in_w_q) ? ST_DONE : ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (in_cnt_q != in_w_q) begin
          in_ready = 1'b1;
          if (in_valid && (in_cnt_q == in_w_q - LINE_W'(1))) begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched configuration, pixel counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      in_w_q    <= '0;
      out_w_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_DONE);
      if ((state_q == ST_IDLE) && start) begin
        step_q    <= cfg_step;
        in_w_q    <= cfg_in_w;
        out_w_q   <= cfg_out_w;
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
        err_q     <= bad_cfg;
      end else begin
        if (in_xfer) begin
          in_cnt_q <= in_cnt_q + LINE_W'(1);
        end
        if (out_xfer) begin
          out_cnt_q <= out_cnt_q + LINE_W'(1);
        end
      end
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign cfg_err  = err_q;
  assign out_dx   = acc_dx;
  assign out_idx  = acc_idx[LINE_W-1:0];
  assign out_edge = out_valid && (idx_p1 >= {1'b0, in_w_q});
  assign out_last = out_valid && last_out;

endmodule

// File: tb/tb_scaler_phase_ctrl.sv
// Directed bench for scaler_phase_ctrl with STEP=4096.
// Table of line configurations with hand-computed totals, plus reset and stall sequences.
// Descriptors are checked against pos(k) = k*step as each one is accepted.
module tb_scaler_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_step;
  logic [11:0] cfg_in_w, cfg_out_w;
  logic        start, busy, done, cfg_err;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [10:0] out_dx;
  logic [11:0] out_idx;
  logic        out_edge, out_last;

  scaler_phase_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_step  (cfg_step),
    .cfg_in_w  (cfg_in_w),
    .cfg_out_w (cfg_out_w),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dx    (out_dx),
    .out_idx   (out_idx),
    .out_edge  (out_edge),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int in_w;
    int out_w;
    int step;
    int n_in;        // expected input transfers for the line
    int n_out;       // expected output descriptors
    int last_idx;    // source index of the final descriptor
    bit err;
    bit gaps;        // randomise in_valid
    int stall_k;     // descriptor to hold off for 5 cycles, -1 none
    bit busy_start;  // pulse start mid-line
  } vec_t;

  vec_t vecs[10];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_cfg_err"},   32'(cfg_err),   32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_out_edge"},  32'(out_edge),  32'd0);
    chk({tag, "_out_dx"},    32'(out_dx),    32'd0);
    chk({tag, "_out_idx"},   32'(out_idx),   32'd0);
  endtask

  // One line: start, drive until done (or abort with rst when descriptor abort_k shows).
  task automatic run_line(input vec_t v, input int abort_k);
    int          n_in, n_out, n_done, n_both, stall_cnt, done_cyc, pos, e_idx;
    bit          finished, aborted;
    logic [31:0] got_last_idx;
    n_in = 0; n_out = 0; n_done = 0; n_both = 0; stall_cnt = 0;
    done_cyc = -1; finished = 1'b0; aborted = 1'b0; got_last_idx = '0;

    @(posedge clk); #1;
    cfg_in_w  = v.in_w[11:0];
    cfg_out_w = v.out_w[11:0];
    cfg_step  = v.step[15:0];
    start     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Garbage on the config pins from here on: the latched copy must be used.
    cfg_in_w = 12'd1; cfg_out_w = 12'd0; cfg_step = 16'd0;
    chk("busy_after_start", 32'(busy),     32'd1);
    chk("first_in_ready",   32'(in_ready), 32'(!v.err));
    chk("cfg_err_early",    32'(cfg_err),  32'(v.err));

    for (int cyc = 1; cyc < 600 && !finished; cyc++) begin
      if (in_ready && out_valid) n_both++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          chk("busy_at_done", 32'(busy), 32'd0);
        end
      end
      if (abort_k >= 0 && out_valid && n_out == abort_k) begin
        aborted  = 1'b1;
        finished = 1'b1;
      end else begin
        in_valid  = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        start     = v.busy_start && (cyc == 3);
        out_ready = 1'b1;
        if (out_valid) begin
          pos   = n_out * v.step;
          e_idx = pos / 4096;
          if (n_out == v.stall_k && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
            chk("stall_idx",      32'(out_idx),  32'(e_idx));
            chk("stall_dx",       32'(out_dx),   32'((pos % 4096) / 2));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
          end else begin
            chk("idx",  32'(out_idx),  32'(e_idx));
            chk("dx",   32'(out_dx),   32'((pos % 4096) / 2));
            chk("edge", 32'(out_edge), 32'(e_idx + 1 >= v.in_w));
            chk("last", 32'(out_last), 32'(n_out == v.out_w - 1));
            got_last_idx = 32'(out_idx);
            n_out++;
          end
        end
        if (in_valid && in_ready) n_in++;
        if (done_cyc >= 0 && cyc >= done_cyc + 3) finished = 1'b1;
      end
      if (!finished) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;

    if (aborted) begin
      rst      = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk_reset("midline_rst");
      rst = 1'b0;
    end else begin
      chk("done_pulses",  32'(n_done),  32'd1);
      chk("in_transfers", 32'(n_in),    32'(v.n_in));
      chk("out_count",    32'(n_out),   32'(v.n_out));
      chk("ready_valid_overlap", 32'(n_both), 32'd0);
      chk("cfg_err_end",  32'(cfg_err), 32'(v.err));
      if (v.n_out > 0) chk("last_idx", got_last_idx, 32'(v.last_idx));
      if (v.err) chk("done_cycle", 32'(done_cyc), 32'd2);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_step = '0; cfg_in_w = '0; cfg_out_w = '0;

    //          in  out  step  n_in n_out last  err   gaps  stall busy_start
    vecs[0] = '{4,  8,   2048, 4,   8,    3,    1'b0, 1'b0, -1,   1'b0}; // up x2
    vecs[1] = '{8,  4,   8192, 8,   4,    6,    1'b0, 1'b0, -1,   1'b0}; // down x2
    vecs[2] = '{8,  2,   8192, 8,   2,    2,    1'b0, 1'b0, -1,   1'b0}; // long tail drain
    vecs[3] = '{16, 16,  4096, 16,  16,   15,   1'b0, 1'b1, -1,   1'b0}; // 1:1, in_valid gaps
    vecs[4] = '{4,  8,   2048, 4,   8,    3,    1'b0, 1'b0, 3,    1'b0}; // downstream stall
    vecs[5] = '{1,  4,   4096, 0,   0,    0,    1'b1, 1'b0, -1,   1'b0}; // in_w too small
    vecs[6] = '{4,  4,   0,    0,   0,    0,    1'b1, 1'b0, -1,   1'b0}; // zero step
    vecs[7] = '{5,  7,   2926, 5,   7,    4,    1'b0, 1'b0, -1,   1'b0}; // non-integer ratio
    vecs[8] = '{6,  6,   4096, 6,   6,    5,    1'b0, 1'b0, -1,   1'b1}; // start while busy
    vecs[9] = '{4,  0,   4096, 0,   0,    0,    1'b1, 1'b0, -1,   1'b0}; // zero out_w

    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_line(vecs[i], -1);

    // Reset while the third descriptor is on offer, then the same line again.
    run_line(vecs[0], 2);
    run_line(vecs[0], -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
